// File: rtl/ipfilter_pkg.sv
// Shared constants, types and helpers for the IPv4 filter AXI-Lite register file.
package ipfilter_pkg;

  localparam logic [31:0] IpfId = 32'h1F17_0002;

  localparam logic [11:0] OffId         = 12'h000;
  localparam logic [11:0] OffNumEntries = 12'h004;
  localparam logic [11:0] OffCtrl       = 12'h008;
  localparam logic [11:0] OffCommit     = 12'h00C;
  localparam logic [11:0] OffTxDrop     = 12'h010;
  localparam logic [11:0] OffRxDrop     = 12'h014;
  localparam logic [11:0] OffCntClr     = 12'h018;

  localparam logic [15:0] TxBase      = 16'h1000;
  localparam logic [15:0] RxBase      = 16'h2000;
  localparam int unsigned EntryStride = 16;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {
    FldCtrl = 2'd0,
    FldAddr = 2'd1,
    FldMask = 2'd2,
    FldRsvd = 2'd3
  } field_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] addr;
    logic [31:0] mask;
  } entry_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ipfilter_entry_bank.sv
// One direction's rule table: shadow copy written by software, active copy driving the filter,
// swapped atomically on commit.
module ipfilter_entry_bank
  import ipfilter_pkg::*;
#(
  parameter int unsigned  NUM_ENTRIES = 16,
  localparam int unsigned IdxW        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [IdxW-1:0]        wr_idx_i,
  input  field_e                 wr_field_i,
  input  logic [31:0]            wr_data_i,
  input  logic [3:0]             wr_strb_i,
  input  logic                   commit_i,
  input  logic [IdxW-1:0]        rd_idx_i,
  input  field_e                 rd_field_i,
  output logic [31:0]            rd_data_o,
  output logic [NUM_ENTRIES-1:0] vld_o,
  output logic [31:0]            addr_o [NUM_ENTRIES],
  output logic [31:0]            mask_o [NUM_ENTRIES]
);

  entry_t shadow_q [NUM_ENTRIES];
  entry_t shadow_d [NUM_ENTRIES];
  entry_t active_q [NUM_ENTRIES];
  entry_t active_d [NUM_ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Commit and a shadow write never coincide: both come from the single write path.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (commit_i) active_d = shadow_q;
    if (we_i) begin
      unique case (wr_field_i)
        FldCtrl: if (wr_strb_i[0]) shadow_d[wr_idx_i].vld = wr_data_i[0];
        FldAddr: shadow_d[wr_idx_i].addr = strb_merge(shadow_q[wr_idx_i].addr, wr_data_i, wr_strb_i);
        FldMask: shadow_d[wr_idx_i].mask = strb_merge(shadow_q[wr_idx_i].mask, wr_data_i, wr_strb_i);
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (rd_field_i)
      FldCtrl: rd_data_o = {31'b0, shadow_q[rd_idx_i].vld};
      FldAddr: rd_data_o = shadow_q[rd_idx_i].addr;
      FldMask: rd_data_o = shadow_q[rd_idx_i].mask;
      default: rd_data_o = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      vld_o[i]  = active_q[i].vld;
      addr_o[i] = active_q[i].addr;
      mask_o[i] = active_q[i].mask;
    end
  end

endmodule

// File: rtl/ipfilter_regfile.sv
// AXI4-Lite register file for the IPv4 filter: decode, AXI-Lite channel FSMs, CTRL, commit
// counter, drop-counter sampling and clear pulses; rule tables live in ipfilter_entry_bank.
module ipfilter_regfile
  import ipfilter_pkg::*;
#(
  parameter int unsigned  ADDR_WIDTH  = 16,
  parameter int unsigned  DATA_WIDTH  = 32,
  parameter int unsigned  NUM_ENTRIES = 16,
  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  s_axil_awaddr,
  input  logic [2:0]             s_axil_awprot,
  input  logic                   s_axil_awvalid,
  output logic                   s_axil_awready,
  input  logic [DATA_WIDTH-1:0]  s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]  s_axil_wstrb,
  input  logic                   s_axil_wvalid,
  output logic                   s_axil_wready,
  output logic [1:0]             s_axil_bresp,
  output logic                   s_axil_bvalid,
  input  logic                   s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]  s_axil_araddr,
  input  logic [2:0]             s_axil_arprot,
  input  logic                   s_axil_arvalid,
  output logic                   s_axil_arready,
  output logic [DATA_WIDTH-1:0]  s_axil_rdata,
  output logic [1:0]             s_axil_rresp,
  output logic                   s_axil_rvalid,
  input  logic                   s_axil_rready,
  output logic [NUM_ENTRIES-1:0] tx_vld,
  output logic [NUM_ENTRIES-1:0] rx_vld,
  output logic [31:0]            tx_ipv4_addr [NUM_ENTRIES],
  output logic [31:0]            rx_ipv4_addr [NUM_ENTRIES],
  output logic [31:0]            tx_ipv4_netmask [NUM_ENTRIES],
  output logic [31:0]            rx_ipv4_netmask [NUM_ENTRIES],
  output logic                   tx_default_deny,
  output logic                   rx_default_deny,
  output logic                   tx_cnt_clr,
  output logic                   rx_cnt_clr,
  input  logic [31:0]            tx_drop_cnt,
  input  logic [31:0]            rx_drop_cnt
);

  localparam int unsigned IdxW      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned RegionW   = ADDR_WIDTH - 12;
  localparam int unsigned StrideLsb = $clog2(EntryStride);

  typedef enum logic [1:0] {StWIdle, StWHold, StWResp} wstate_e;
  typedef enum logic {StRIdle, StRResp} rstate_e;

  typedef struct packed {
    logic            ok;
    logic            misc;
    logic            tx;
    logic            rx;
    logic [IdxW-1:0] idx;
    field_e          field;
    logic [11:0]     off;
  } dec_t;

  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] a);
    dec_t               d;
    logic [RegionW-1:0] region;
    region  = a[ADDR_WIDTH-1:12];
    d       = '0;
    d.off   = a[11:0] & 12'hFFC;
    d.idx   = a[StrideLsb +: IdxW];
    d.field = field_e'(a[3:2]);
    if (region == RegionW'(TxBase >> 12)) begin
      d.tx = 1'b1;
      d.ok = 32'(a[StrideLsb +: 8]) < NUM_ENTRIES;
    end else if (region == RegionW'(RxBase >> 12)) begin
      d.rx = 1'b1;
      d.ok = 32'(a[StrideLsb +: 8]) < NUM_ENTRIES;
    end else if (region == '0) begin
      d.misc = 1'b1;
      d.ok   = (d.off <= OffCntClr);
    end
    return d;
  endfunction

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [1:0]            ctrl_q, ctrl_d, deny_q, deny_d, clr_q, clr_d;
  logic [15:0]           commit_cnt_q, commit_cnt_d;
  logic [31:0]           tx_drop_q, rx_drop_q;

  dec_t        wdec, rdec;
  logic        wr_fire, commit_en, tx_we, rx_we;
  logic [31:0] tx_rd_data, rx_rd_data, rd_val;
  logic        unused_prot;

  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};
  assign wdec = decode(awaddr_q);
  assign rdec = decode(s_axil_araddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q     <= StWIdle;
      rstate_q     <= StRIdle;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bresp_q      <= '0;
      rresp_q      <= '0;
      rdata_q      <= '0;
      ctrl_q       <= '0;
      deny_q       <= '0;
      clr_q        <= '0;
      commit_cnt_q <= '0;
      tx_drop_q    <= '0;
      rx_drop_q    <= '0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bresp_q      <= bresp_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      ctrl_q       <= ctrl_d;
      deny_q       <= deny_d;
      clr_q        <= clr_d;
      commit_cnt_q <= commit_cnt_d;
      tx_drop_q    <= tx_drop_cnt;
      rx_drop_q    <= rx_drop_cnt;
    end
  end

  always_comb begin
    wstate_d     = wstate_q;
    rstate_d     = rstate_q;
    aw_held_d    = aw_held_q;
    w_held_d     = w_held_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bresp_d      = bresp_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    ctrl_d       = ctrl_q;
    deny_d       = deny_q;
    clr_d        = '0;
    commit_cnt_d = commit_cnt_q;

    unique case (wstate_q)
      StWIdle: begin
        if (s_axil_awvalid && !aw_held_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axil_awaddr;
        end
        if (s_axil_wvalid && !w_held_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil_wdata;
          wstrb_d  = s_axil_wstrb;
        end
        if (aw_held_d && w_held_d) wstate_d = StWHold;
      end
      StWHold: begin
        wstate_d = StWResp;
        bresp_d  = wdec.ok ? RespOkay : RespSlverr;
      end
      StWResp: begin
        if (s_axil_bready) begin
          wstate_d  = StWIdle;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: wstate_d = StWIdle;
    endcase

    if (wr_fire && wdec.misc) begin
      case (wdec.off)
        OffCtrl:   if (wstrb_q[0]) ctrl_d = wdata_q[1:0];
        OffCntClr: if (wstrb_q[0]) clr_d = wdata_q[1:0];
        default: ;
      endcase
    end
    if (commit_en) begin
      deny_d       = ctrl_q;
      commit_cnt_d = commit_cnt_q + 16'd1;
    end

    unique case (rstate_q)
      StRIdle: begin
        if (s_axil_arvalid) begin
          rstate_d = StRResp;
          rdata_d  = rdec.ok ? DATA_WIDTH'(rd_val) : '0;
          rresp_d  = rdec.ok ? RespOkay : RespSlverr;
        end
      end
      StRResp: if (s_axil_rready) rstate_d = StRIdle;
      default: rstate_d = StRIdle;
    endcase
  end

  always_comb begin
    s_axil_awready = !aw_held_q;
    s_axil_wready  = !w_held_q;
    s_axil_bvalid  = (wstate_q == StWResp);
    s_axil_arready = (rstate_q == StRIdle);
    s_axil_rvalid  = (rstate_q == StRResp);
    wr_fire        = (wstate_q == StWHold) && wdec.ok;
    commit_en      = wr_fire && wdec.misc && (wdec.off == OffCommit) && wstrb_q[0] && wdata_q[0];
    tx_we          = wr_fire && wdec.tx;
    rx_we          = wr_fire && wdec.rx;
  end

  always_comb begin
    rd_val = '0;
    if (rdec.tx) begin
      rd_val = tx_rd_data;
    end else if (rdec.rx) begin
      rd_val = rx_rd_data;
    end else begin
      case (rdec.off)
        OffId:         rd_val = IpfId;
        OffNumEntries: rd_val = 32'(NUM_ENTRIES);
        OffCtrl:       rd_val = {30'b0, ctrl_q};
        OffCommit:     rd_val = {16'b0, commit_cnt_q};
        OffTxDrop:     rd_val = tx_drop_q;
        OffRxDrop:     rd_val = rx_drop_q;
        default:       rd_val = '0;
      endcase
    end
  end

  assign s_axil_bresp    = bresp_q;
  assign s_axil_rresp    = rresp_q;
  assign s_axil_rdata    = rdata_q;
  assign tx_default_deny = deny_q[0];
  assign rx_default_deny = deny_q[1];
  assign tx_cnt_clr      = clr_q[0];
  assign rx_cnt_clr      = clr_q[1];

  ipfilter_entry_bank #(.NUM_ENTRIES(NUM_ENTRIES)) u_tx_bank (
    .clk        (clk),
    .rst        (rst),
    .we_i       (tx_we),
    .wr_idx_i   (wdec.idx),
    .wr_field_i (wdec.field),
    .wr_data_i  (wdata_q[31:0]),
    .wr_strb_i  (wstrb_q[3:0]),
    .commit_i   (commit_en),
    .rd_idx_i   (rdec.idx),
    .rd_field_i (rdec.field),
    .rd_data_o  (tx_rd_data),
    .vld_o      (tx_vld),
    .addr_o     (tx_ipv4_addr),
    .mask_o     (tx_ipv4_netmask)
  );

  ipfilter_entry_bank #(.NUM_ENTRIES(NUM_ENTRIES)) u_rx_bank (
    .clk        (clk),
    .rst        (rst),
    .we_i       (rx_we),
    .wr_idx_i   (wdec.idx),
    .wr_field_i (wdec.field),
    .wr_data_i  (wdata_q[31:0]),
    .wr_strb_i  (wstrb_q[3:0]),
    .commit_i   (commit_en),
    .rd_idx_i   (rdec.idx),
    .rd_field_i (rdec.field),
    .rd_data_o  (rx_rd_data),
    .vld_o      (rx_vld),
    .addr_o     (rx_ipv4_addr),
    .mask_o     (rx_ipv4_netmask)
  );

endmodule
